gauss_smooth: RTL and testbench
===============================

GAUSS_SMOOTH -- requirements
Module: gauss_smooth

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in  input  8  unsigned pixel of a 64x64 raster stream (row-major, row 0 first), fed from the scale-down stage's out.
REQ-005 in_valid  input  1  fed from the scale-down stage's display; qualifies in; one pixel accepted per cycle with in_valid=1; arbitrary gaps allowed; no backpressure.
REQ-006 out  output  8  smoothed pixel, registered.
REQ-007 display  output  1  out valid this cycle.
REQ-008 frame_done  output  1  one-cycle pulse coincident with output pixel 4095.
REQ-009 overrun  output  1  sticky error flag; cleared only by reset.

Function
REQ-010 Input index k = 64*R + C SHALL count accepted pixels 0..4095; output index j = 64*r + c SHALL count emitted pixels 0..4095, both in raster order.
REQ-011 Interior pixel (1<=r<=62, 1<=c<=62): out SHALL be (sum(w*p) + 8) >> 4, with kernel rows [1 2 1; 2 4 2; 1 2 1] centred on p(r,c); accumulator 12 bits, no overflow, result always <=255.
REQ-012 Border pixel (r in {0,63} or c in {0,63}): out SHALL equal the input pixel p(r,c) unchanged.
REQ-013 Storage: two 64-byte line buffers plus a 3x3 window register set; no full-frame storage.
REQ-014 FSM states: FILL, RUN, FLUSH.
REQ-015 FILL (reset state): accept k=0..64 with no output; accepting k=64 SHALL move to RUN.
REQ-016 RUN: accepting k (65<=k<=4095) SHALL emit j=k-65 with display=1 on the next cycle; display=0 in cycles after no acceptance.
REQ-017 Accepting k=4095 SHALL move to FLUSH.
REQ-018 FLUSH: emit j=4031..4095 on 65 consecutive cycles, display=1 each cycle; frame_done=1 with j=4095; then go to FILL with k=0, j=0.
REQ-019 in_valid=1 during FLUSH SHALL be dropped (not stored, not counted) and SHALL set overrun=1; the emitted stream SHALL be unaffected.
REQ-020 The first pixel accepted after returning to FILL SHALL be k=0 of the next frame; no state carries between frames.
REQ-021 Wrap-around: line-buffer and window updates at C=63 -> C=0 SHALL never mix pixels of different rows into an interior result.

Reset
REQ-022 With reset=1 at a rising edge: state=FILL, k=0, j=0, out=0, display=0, frame_done=0, overrun=0.
REQ-023 Line-buffer contents need not be cleared; no output SHALL depend on pre-reset data.
REQ-024 Reset asserted mid-frame (any state, including FLUSH) SHALL abort the frame with no further display until a new frame reaches k=65.
REQ-025 reset has priority over in_valid in the same cycle; that pixel is discarded.

Verification
REQ-026 Flat frame, all pixels 100, in_valid continuous -> 4096 outputs, all 100; first display the cycle after k=65; frame_done exactly once, with output 4095; overrun=0.
REQ-027 Impulse p(10,10)=160, others 0 -> out(10,10)=40, out(9,10)=20, out(10,11)=20, out(9,9)=10, out(11,11)=10; all other outputs 0.
REQ-028 All 255 -> all outputs 255 (interior sum 4080+8=4088 >> 4 = 255); ramp p(r,c)=c*4 -> rows 0/63 and cols 0/63 equal input, interior out=c*4.
REQ-029 Random frame with random in_valid gaps (0-5 cycles) -> output sequence identical to the gap-free run; each RUN output exactly one cycle after its triggering acceptance.
REQ-030 Reset asserted at k=2000, then a full new frame -> new frame output bit-exact to a golden model; one in_valid pulse inserted during FLUSH -> overrun=1 and stays 1; all outputs unchanged.

Source files
------------

// File: rtl/gauss_smooth.sv
// 3x3 Gaussian smoother for a 64x64 raster stream; border pixels pass through unchanged.
// Two line buffers plus a sliding 3-column window; output lags input by one row plus one pixel.
module gauss_smooth (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in,
  input  logic       in_valid,
  output logic [7:0] out,
  output logic       display,
  output logic       frame_done,
  output logic       overrun
);

  typedef enum logic [1:0] {FILL, RUN, FLUSH} state_t;

  state_t state, state_nxt;

  // k counts accepted pixels 0..4095, then continues 4096..4160 as virtual flush steps.
  logic [12:0] k;
  logic [12:0] j_idx;
  logic [5:0]  col;
  logic        accept, emit, last_out, border;

  logic [7:0]       lb1 [64];
  logic [7:0]       lb2 [64];
  logic [2:0][7:0]  win_a, win_b, col_new;
  logic [11:0]      sum;
  logic [7:0]       smooth;

  assign col   = k[5:0];
  assign j_idx = k - 13'd65;
  assign border = (j_idx[11:6] == 6'd0) || (j_idx[11:6] == 6'd63) ||
                  (j_idx[5:0]  == 6'd0) || (j_idx[5:0]  == 6'd63);

  always_ff @(posedge clk) begin
    if (reset) state <= FILL;
    else       state <= state_nxt;
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    emit      = 1'b0;
    last_out  = 1'b0;
    case (state)
      FILL: begin
        if (in_valid) begin
          accept = 1'b1;
          if (k == 13'd64) state_nxt = RUN;
        end
      end
      RUN: begin
        if (in_valid) begin
          accept = 1'b1;
          emit   = 1'b1;
          if (k == 13'd4095) state_nxt = FLUSH;
        end
      end
      FLUSH: begin
        emit = 1'b1;
        if (k == 13'd4160) begin
          last_out  = 1'b1;
          state_nxt = FILL;
        end
      end
      default: state_nxt = FILL;
    endcase
  end

  // Newest column of the window: rows R-2, R-1, R at the current column.
  always_comb begin
    col_new[0] = lb2[col];
    col_new[1] = lb1[col];
    col_new[2] = (state == FLUSH) ? 8'd0 : in;
  end

  // win_b = column c-1, win_a = column c (centre), col_new = column c+1.
  always_comb begin
    sum = 12'd8
        + 12'(win_b[0]) + 12'(win_b[2]) + 12'(col_new[0]) + 12'(col_new[2])
        + ((12'(win_a[0]) + 12'(win_a[2]) + 12'(win_b[1]) + 12'(col_new[1])) << 1)
        + (12'(win_a[1]) << 2);
    smooth = sum[11:4];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      k          <= '0;
      out        <= '0;
      display    <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      display    <= emit;
      frame_done <= last_out;
      if (emit) out <= border ? win_a[1] : smooth;
      if (state == FLUSH && in_valid) overrun <= 1'b1;
      if (last_out)           k <= '0;
      else if (accept || emit) k <= k + 13'd1;
    end
  end

  // NOTE: line buffers and window carry no reset; every value reaching out is rewritten by the current frame first.
  always_ff @(posedge clk) begin
    if (accept && !reset) begin
      lb1[col] <= in;
      lb2[col] <= lb1[col];
    end
    if ((accept || emit) && !reset) begin
      win_b <= win_a;
      win_a <= col_new;
    end
  end

endmodule

// File: tb/tb_gauss_smooth.sv
// Directed bench for gauss_smooth: reset, flat, impulse, saturation, ramp, gaps, mid-frame reset, overrun.
module tb_gauss_smooth;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in;
  logic       in_valid;
  logic [7:0] out;
  logic       display;
  logic       frame_done;
  logic       overrun;

  gauss_smooth dut (
    .clk        (clk),
    .reset      (reset),
    .in         (in),
    .in_valid   (in_valid),
    .out        (out),
    .display    (display),
    .frame_done (frame_done),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  int pix     [4096];
  int expv    [4096];
  int refv    [4096];
  int cap_val [4096];
  int cap_cyc [4096];
  int acc_cyc [4096];
  int cap_n  = 0;
  int fd_cnt = 0;
  int fd_at  = -1;

  always @(negedge clk) begin
    if (frame_done) begin
      fd_cnt = fd_cnt + 1;
      fd_at  = cap_n;
    end
    if (display) begin
      if (cap_n < 4096) begin
        cap_val[cap_n] = int'(out);
        cap_cyc[cap_n] = cyc;
      end
      cap_n = cap_n + 1;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_cap();
    cap_n  = 0;
    fd_cnt = 0;
    fd_at  = -1;
    for (int i = 0; i < 4096; i++) begin
      cap_val[i] = -1;
      cap_cyc[i] = -1;
    end
  endtask

  // Streams pix[] with random idle gaps; optionally pulses in_valid ovr_at cycles into FLUSH.
  task automatic run_frame(input int max_gap, input int ovr_at);
    clear_cap();
    for (int k = 0; k < 4096; k++) begin
      in_valid = 1'b0;
      tick((max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
      in_valid   = 1'b1;
      in         = 8'(pix[k]);
      acc_cyc[k] = cyc + 1;
      tick(1);
    end
    in_valid = 1'b0;
    if (ovr_at >= 0) begin
      tick(ovr_at);
      in_valid = 1'b1;
      in       = 8'hAA;
      tick(1);
      in_valid = 1'b0;
    end
    for (int t = 0; t < 300 && cap_n < 4096; t++) tick(1);
    tick(5);
  endtask

  // Independent golden model: direct 3x3 weighted sum over the stored frame.
  function automatic void build_golden();
    for (int i = 0; i < 4096; i++) begin
      int r, c, s;
      r = i / 64;
      c = i % 64;
      if (r == 0 || r == 63 || c == 0 || c == 63) begin
        expv[i] = pix[i];
      end else begin
        s = 8;
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++)
            s += ((dr == 0) ? 2 : 1) * ((dc == 0) ? 2 : 1) * pix[(r + dr) * 64 + c + dc];
        expv[i] = s >> 4;
      end
    end
  endfunction

  task automatic test_reset();
    reset    = 1'b1;
    in_valid = 1'b1;
    in       = 8'h55;
    tick(2);
    n_vec++; if (out !== 8'd0)        begin n_err++; $display("FAIL reset_out: got %0d expected 0", out); end
    n_vec++; if (display !== 1'b0)    begin n_err++; $display("FAIL reset_display: got %b expected 0", display); end
    n_vec++; if (frame_done !== 1'b0) begin n_err++; $display("FAIL reset_frame_done: got %b expected 0", frame_done); end
    n_vec++; if (overrun !== 1'b0)    begin n_err++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
    reset    = 1'b0;
    in_valid = 1'b0;
    clear_cap();
    tick(4);
    n_vec++; if (cap_n !== 0) begin n_err++; $display("FAIL idle_display: got %0d outputs expected 0", cap_n); end
  endtask

  task automatic test_flat();
    for (int i = 0; i < 4096; i++) pix[i] = 100;
    run_frame(0, -1);
    n_vec++; if (cap_n !== 4096) begin n_err++; $display("FAIL flat_count: got %0d expected 4096", cap_n); end
    for (int j = 0; j < 4096; j++) begin
      n_vec++;
      if (cap_val[j] !== 100) begin n_err++; $display("FAIL flat_pix[%0d]: got %0d expected 100", j, cap_val[j]); end
    end
    n_vec++; if (cap_cyc[0] !== acc_cyc[65]) begin n_err++; $display("FAIL flat_first_latency: got cycle %0d expected %0d", cap_cyc[0], acc_cyc[65]); end
    n_vec++; if (fd_cnt !== 1 || fd_at !== 4095) begin n_err++; $display("FAIL flat_frame_done: got count %0d at %0d expected 1 at 4095", fd_cnt, fd_at); end
    n_vec++; if (overrun !== 1'b0) begin n_err++; $display("FAIL flat_overrun: got %b expected 0", overrun); end
  endtask

  task automatic test_impulse();
    int imp_v [3][3] = '{'{10, 20, 10}, '{20, 40, 20}, '{10, 20, 10}};
    for (int i = 0; i < 4096; i++) begin
      pix[i]  = 0;
      expv[i] = 0;
    end
    pix[10 * 64 + 10] = 160;
    for (int a = 0; a < 3; a++)
      for (int b = 0; b < 3; b++)
        expv[(9 + a) * 64 + 9 + b] = imp_v[a][b];
    run_frame(0, -1);
    n_vec++; if (cap_n !== 4096) begin n_err++; $display("FAIL impulse_count: got %0d expected 4096", cap_n); end
    for (int j = 0; j < 4096; j++) begin
      n_vec++;
      if (cap_val[j] !== expv[j]) begin n_err++; $display("FAIL impulse_pix[%0d]: got %0d expected %0d", j, cap_val[j], expv[j]); end
    end
  endtask

  task automatic test_saturate_ramp();
    for (int i = 0; i < 4096; i++) pix[i] = 255;
    run_frame(0, -1);
    n_vec++; if (cap_n !== 4096) begin n_err++; $display("FAIL sat_count: got %0d expected 4096", cap_n); end
    for (int j = 0; j < 4096; j++) begin
      n_vec++;
      if (cap_val[j] !== 255) begin n_err++; $display("FAIL sat_pix[%0d]: got %0d expected 255", j, cap_val[j]); end
    end
    // A horizontal ramp is linear, so interior and border outputs both equal c*4.
    for (int i = 0; i < 4096; i++) pix[i] = (i % 64) * 4;
    run_frame(0, -1);
    n_vec++; if (cap_n !== 4096) begin n_err++; $display("FAIL ramp_count: got %0d expected 4096", cap_n); end
    for (int j = 0; j < 4096; j++) begin
      n_vec++;
      if (cap_val[j] !== (j % 64) * 4) begin n_err++; $display("FAIL ramp_pix[%0d]: got %0d expected %0d", j, cap_val[j], (j % 64) * 4); end
    end
  endtask

  task automatic test_gaps();
    for (int i = 0; i < 4096; i++) pix[i] = int'($urandom_range(0, 255));
    build_golden();
    run_frame(0, -1);
    n_vec++; if (cap_n !== 4096) begin n_err++; $display("FAIL rand_count: got %0d expected 4096", cap_n); end
    for (int j = 0; j < 4096; j++) begin
      refv[j] = expv[j];
      n_vec++;
      if (cap_val[j] !== expv[j]) begin n_err++; $display("FAIL rand_pix[%0d]: got %0d expected %0d", j, cap_val[j], expv[j]); end
    end
    run_frame(5, -1);
    n_vec++; if (cap_n !== 4096) begin n_err++; $display("FAIL gap_count: got %0d expected 4096", cap_n); end
    for (int j = 0; j < 4096; j++) begin
      n_vec++;
      if (cap_val[j] !== refv[j]) begin n_err++; $display("FAIL gap_pix[%0d]: got %0d expected %0d", j, cap_val[j], refv[j]); end
    end
    for (int j = 0; j < 4031; j++) begin
      n_vec++;
      if (cap_cyc[j] !== acc_cyc[j + 65]) begin n_err++; $display("FAIL gap_latency[%0d]: got cycle %0d expected %0d", j, cap_cyc[j], acc_cyc[j + 65]); end
    end
    for (int j = 4031; j < 4096; j++) begin
      n_vec++;
      if (cap_cyc[j] !== acc_cyc[4095] + (j - 4030)) begin n_err++; $display("FAIL flush_timing[%0d]: got cycle %0d expected %0d", j, cap_cyc[j], acc_cyc[4095] + (j - 4030)); end
    end
    n_vec++; if (fd_cnt !== 1 || fd_at !== 4095) begin n_err++; $display("FAIL gap_frame_done: got count %0d at %0d expected 1 at 4095", fd_cnt, fd_at); end
  endtask

  task automatic test_reset_mid_overrun();
    for (int i = 0; i < 4096; i++) pix[i] = int'($urandom_range(0, 255));
    clear_cap();
    for (int k = 0; k < 2000; k++) begin
      in_valid = 1'b1;
      in       = 8'(pix[k]);
      tick(1);
    end
    in       = 8'(pix[2000]);
    reset    = 1'b1;
    tick(2);
    reset    = 1'b0;
    in_valid = 1'b0;
    n_vec++; if (display !== 1'b0) begin n_err++; $display("FAIL midreset_display: got %b expected 0", display); end
    n_vec++; if (overrun !== 1'b0) begin n_err++; $display("FAIL midreset_overrun: got %b expected 0", overrun); end
    clear_cap();
    tick(6);
    n_vec++; if (cap_n !== 0) begin n_err++; $display("FAIL midreset_idle: got %0d outputs expected 0", cap_n); end
    for (int i = 0; i < 4096; i++) pix[i] = int'($urandom_range(0, 255));
    build_golden();
    run_frame(0, 10);
    n_vec++; if (cap_n !== 4096) begin n_err++; $display("FAIL newframe_count: got %0d expected 4096", cap_n); end
    for (int j = 0; j < 4096; j++) begin
      n_vec++;
      if (cap_val[j] !== expv[j]) begin n_err++; $display("FAIL newframe_pix[%0d]: got %0d expected %0d", j, cap_val[j], expv[j]); end
    end
    n_vec++; if (cap_cyc[0] !== acc_cyc[65]) begin n_err++; $display("FAIL newframe_latency: got cycle %0d expected %0d", cap_cyc[0], acc_cyc[65]); end
    n_vec++; if (fd_cnt !== 1 || fd_at !== 4095) begin n_err++; $display("FAIL newframe_frame_done: got count %0d at %0d expected 1 at 4095", fd_cnt, fd_at); end
    n_vec++; if (overrun !== 1'b1) begin n_err++; $display("FAIL overrun_set: got %b expected 1", overrun); end
    tick(20);
    n_vec++; if (overrun !== 1'b1) begin n_err++; $display("FAIL overrun_sticky: got %b expected 1", overrun); end
    n_vec++; if (cap_n !== 4096) begin n_err++; $display("FAIL post_flush_idle: got %0d outputs expected 4096", cap_n); end
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in       = 8'd0;
    tick(1);
    test_reset();
    test_flat();
    test_impulse();
    test_saturate_ramp();
    test_gaps();
    test_reset_mid_overrun();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
